// File: rtl/fir_pkg.sv
// Shared types and constants for the time-multiplexed 3-tap FIR sequencer.
package fir_pkg;

  localparam int DW_DEF = 16;
  localparam int AW_DEF = 32;

  localparam logic [1:0] H0_ADDR = 2'd0;
  localparam logic [1:0] H1_ADDR = 2'd1;
  localparam logic [1:0] H2_ADDR = 2'd2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAC0 = 3'd1,
    MAC1 = 3'd2,
    MAC2 = 3'd3,
    OUT  = 3'd4
  } state_t;

endpackage

// File: rtl/fir3_mac_sequencer_if.sv
// Sample/result handshakes, coefficient write port and status for the FIR sequencer.
interface fir3_mac_sequencer_if #(
  parameter int DW = fir_pkg::DW_DEF,
  parameter int AW = fir_pkg::AW_DEF
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x;
  logic          coef_we;
  logic [1:0]    coef_addr;
  logic [DW-1:0] coef_data;
  logic          clr;
  logic          busy;
  logic          y_valid;
  logic          y_ready;
  logic [AW-1:0] y;

  modport master (
    output in_valid, x, coef_we, coef_addr, coef_data, clr, y_ready,
    input  in_ready, busy, y_valid, y
  );

  modport slave (
    input  in_valid, x, coef_we, coef_addr, coef_data, clr, y_ready,
    output in_ready, busy, y_valid, y
  );
endinterface

// File: rtl/fir_mac_unit.sv
// Shared multiplier plus registered accumulator; unsigned product, modulo-2^AW accumulation.
module fir_mac_unit #(
  parameter int DW = fir_pkg::DW_DEF,
  parameter int AW = fir_pkg::AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          enable,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [AW-1:0] acc
);

  logic [2*DW-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + AW'(prod);
    end
  end

endmodule

// File: rtl/fir3_mac_sequencer.sv
// 3-tap FIR with one shared MAC: coefficient regs, delay line and tap sequencing FSM.
//
//   state | meaning
//   IDLE  | ready for a sample; coefficient writes and clr honoured
//   MAC0  | acc += h0 * d0
//   MAC1  | acc += h1 * d1
//   MAC2  | acc += h2 * d2
//   OUT   | result offered on y until y_ready
module fir3_mac_sequencer
  import fir_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  fir3_mac_sequencer_if.slave bus
);

  state_t        state, state_nxt;
  logic [DW-1:0] d0, d1, d2;
  logic [DW-1:0] h0, h1, h2;
  logic [DW-1:0] mac_a, mac_b;
  logic [AW-1:0] acc;
  logic [AW-1:0] y_q;
  logic          accept;
  logic          mac_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    mac_en    = 1'b0;
    mac_a     = '0;
    mac_b     = '0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = MAC0;
        end
      end
      MAC0: begin
        mac_en    = 1'b1;
        mac_a     = h0;
        mac_b     = d0;
        state_nxt = MAC1;
      end
      MAC1: begin
        mac_en    = 1'b1;
        mac_a     = h1;
        mac_b     = d1;
        state_nxt = MAC2;
      end
      MAC2: begin
        mac_en    = 1'b1;
        mac_a     = h2;
        mac_b     = d2;
        state_nxt = OUT;
      end
      OUT: begin
        if (bus.y_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // in_valid has priority over clr when both arrive in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0 <= '0;
      d1 <= '0;
      d2 <= '0;
    end else if (accept) begin
      d0 <= bus.x;
      d1 <= d0;
      d2 <= d1;
    end else if (state == IDLE && bus.clr) begin
      d0 <= '0;
      d1 <= '0;
      d2 <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0 <= '0;
      h1 <= '0;
      h2 <= '0;
    end else if (state == IDLE && bus.coef_we) begin
      case (bus.coef_addr)
        H0_ADDR: h0 <= bus.coef_data;
        H1_ADDR: h1 <= bus.coef_data;
        H2_ADDR: h2 <= bus.coef_data;
        default: ;
      endcase
    end
  end

  fir_mac_unit #(.DW(DW), .AW(AW)) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .enable (mac_en),
    .a      (mac_a),
    .b      (mac_b),
    .acc    (acc)
  );

  // acc is frozen in OUT; y_q keeps the last result once acc is cleared by the next sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
    end else if (state == OUT) begin
      y_q <= acc;
    end
  end

  assign bus.y        = (state == OUT) ? acc : y_q;
  assign bus.y_valid  = (state == OUT);
  assign bus.in_ready = (state == IDLE);
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_fir3_mac_sequencer.sv
// Directed-vector bench for fir3_mac_sequencer with hand-computed FIR results.
module tb_fir3_mac_sequencer;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   cyc;
  int   acc_cyc;

  fir3_mac_sequencer_if #(.DW(16), .AW(32)) bus ();

  fir3_mac_sequencer #(.DW(16), .AW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input logic [1:0] addr, input logic [15:0] data);
    bus.coef_we   = 1'b1;
    bus.coef_addr = addr;
    bus.coef_data = data;
    tick();
    bus.coef_we   = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
  endtask

  task automatic start(input string tag, input logic [15:0] xv,
                       input logic we, input logic [1:0] addr, input logic [15:0] data,
                       input logic with_clr);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_inrdy"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid  = 1'b1;
    bus.x         = xv;
    bus.coef_we   = we;
    bus.coef_addr = addr;
    bus.coef_data = data;
    bus.clr       = with_clr;
    tick();
    acc_cyc       = cyc;
    bus.in_valid  = 1'b0;
    bus.coef_we   = 1'b0;
    bus.clr       = 1'b0;
  endtask

  task automatic wait_y(input string tag, input logic [31:0] exp);
    int n;
    bit rdy_ok;
    n      = 0;
    rdy_ok = 1'b1;
    while (!bus.y_valid && n < 12) begin
      if (bus.in_ready) rdy_ok = 1'b0;
      tick();
      n++;
    end
    chk({tag, "_yvalid"}, {31'd0, bus.y_valid}, 32'd1);
    chk({tag, "_lat"}, cyc - acc_cyc, 32'd3);
    chk({tag, "_y"}, bus.y, exp);
    chk({tag, "_busyrdy"}, {31'd0, rdy_ok && !bus.in_ready}, 32'd1);
  endtask

  task automatic send(input string tag, input logic [15:0] xv, input logic [31:0] exp);
    start(tag, xv, 1'b0, 2'd3, 16'd0, 1'b0);
    wait_y(tag, exp);
    tick();
    chk({tag, "_idle"}, {30'd0, bus.busy, bus.y_valid}, 32'd0);
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    cyc           = 0;
    acc_cyc       = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.coef_we   = 1'b0;
    bus.coef_addr = 2'd3;
    bus.coef_data = '0;
    bus.clr       = 1'b0;
    bus.y_ready   = 1'b1;
    tick();
    tick();
    chk("rst_y", bus.y, 32'd0);
    chk("rst_flags", {29'd0, bus.y_valid, bus.busy, bus.in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // impulse response
    write_coef(2'd0, 16'd1);
    write_coef(2'd1, 16'd2);
    write_coef(2'd2, 16'd3);
    send("imp0", 16'd1, 32'd1);
    send("imp1", 16'd0, 32'd2);
    send("imp2", 16'd0, 32'd3);
    send("imp3", 16'd0, 32'd0);
    send("cont0", 16'd5, 32'd5);
    send("cont1", 16'd6, 32'd16);

    // backpressure: in_valid held high in OUT must not disturb anything
    bus.y_ready = 1'b0;
    start("bp", 16'd7, 1'b0, 2'd3, 16'd0, 1'b0);
    wait_y("bp", 32'd34);
    bus.in_valid = 1'b1;
    bus.x        = 16'd99;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_y", bus.y, 32'd34);
      chk("bp_hold_flags", {29'd0, bus.y_valid, bus.busy, bus.in_ready}, 32'b110);
    end
    bus.in_valid = 1'b0;
    bus.y_ready  = 1'b1;
    tick();
    chk("bp_release", {30'd0, bus.y_valid, bus.in_ready}, 32'b01);
    chk("bp_y_retained", bus.y, 32'd34);
    send("bp_after", 16'd0, 32'd32);

    // modulo-2^32 wrap
    write_coef(2'd0, 16'hFFFF);
    write_coef(2'd1, 16'hFFFF);
    write_coef(2'd2, 16'hFFFF);
    pulse_clr();
    send("wrap0", 16'hFFFF, 32'hFFFE0001);
    send("wrap1", 16'hFFFF, 32'hFFFC0002);
    send("wrap2", 16'hFFFF, 32'hFFFA0003);

    // coefficient write while busy is dropped; same write in IDLE applies to that sample
    write_coef(2'd0, 16'd1);
    write_coef(2'd1, 16'd2);
    write_coef(2'd2, 16'd3);
    pulse_clr();
    start("cwb", 16'd1, 1'b0, 2'd3, 16'd0, 1'b0);
    tick();
    chk("cwb_in_mac1", {31'd0, bus.busy}, 32'd1);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 2'd1;
    bus.coef_data = 16'd7;
    tick();
    bus.coef_we   = 1'b0;
    wait_y("cwb", 32'd1);
    tick();
    send("cwb_old_h1", 16'd0, 32'd2);
    pulse_clr();
    send("cwi_pre", 16'd1, 32'd1);
    start("cwi", 16'd0, 1'b1, 2'd1, 16'd7, 1'b0);
    wait_y("cwi", 32'd7);
    tick();

    // reset in the middle of a computation
    start("rmid", 16'd9, 1'b0, 2'd3, 16'd0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rmid_flags", {29'd0, bus.y_valid, bus.busy, bus.in_ready}, 32'b001);
    chk("rmid_y", bus.y, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    write_coef(2'd0, 16'd1);
    send("rst_after", 16'd4, 32'd4);

    // clr behaviour, address 3 no-op, in_valid beats clr
    write_coef(2'd1, 16'd2);
    write_coef(2'd2, 16'd3);
    send("pre_clr", 16'd5, 32'd13);
    pulse_clr();
    write_coef(2'd3, 16'h55);
    send("post_clr", 16'd6, 32'd6);
    start("vclr", 16'd2, 1'b0, 2'd3, 16'd0, 1'b1);
    wait_y("vclr", 32'd14);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
